// File: rtl/argmax_pkg.sv
// argmax_pkg: shared types and helpers for the streaming argmax block.
//   argmax_state_e  - frame accumulation FSM states
//   ARGMAX_NUM_SIZE - default score width
//   idx_width()     - index width for a count of items (never below 1 bit)
package argmax_pkg;

  localparam int unsigned ARGMAX_NUM_SIZE = 26;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } argmax_state_e;

  // Width needed to index n items; a zero-width index is widened to 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_stream_if.sv
// argmax_stream_if: score-beat input handshake and result output handshake.
//   InValid/InReady/InData     - input beats, LANES scores per beat
//   OutValid/OutReady          - result handshake
//   OutIndex/OutMax            - frame argmax and its signed score
//   OutIndex2                  - runner-up index (only with ARGMAX_TOP2_EN)
// Modports: master drives beats and consumes results, slave is the argmax block.
interface argmax_stream_if import argmax_pkg::*; #(
  parameter int unsigned NUM_SIZE    = ARGMAX_NUM_SIZE,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned LANES       = 1
);

  localparam int unsigned IDX_W = idx_width(NUM_CLASSES);

  logic                      InValid;
  logic                      InReady;
  logic [LANES*NUM_SIZE-1:0] InData;
  logic                      OutValid;
  logic                      OutReady;
  logic [IDX_W-1:0]          OutIndex;
  logic [NUM_SIZE-1:0]       OutMax;
`ifdef ARGMAX_TOP2_EN
  logic [IDX_W-1:0]          OutIndex2;
`endif

  modport master (
    output InValid, output InData, output OutReady,
    input  InReady, input  OutValid, input  OutIndex, input  OutMax
`ifdef ARGMAX_TOP2_EN
    , input OutIndex2
`endif
  );

  modport slave (
    input  InValid, input  InData, input  OutReady,
    output InReady, output OutValid, output OutIndex, output OutMax
`ifdef ARGMAX_TOP2_EN
    , output OutIndex2
`endif
  );

endinterface

// File: rtl/argmax_lane_reduce.sv
// argmax_lane_reduce: combinational signed max over the LANES scores of one beat.
//   data_i      - LANES packed scores, lane k at [k*NUM_SIZE +: NUM_SIZE]
//   max_c_o     - largest score in the beat
//   lane_c_o    - lowest lane holding that score
//   max2_c_o/lane2_c_o/has2_c_o - runner-up score, lane and presence
//                 (only with ARGMAX_TOP2_EN)
module argmax_lane_reduce import argmax_pkg::*; #(
  parameter int unsigned NUM_SIZE = ARGMAX_NUM_SIZE,
  parameter int unsigned LANES    = 1,
  parameter int unsigned LANE_W   = idx_width(LANES)
) (
  input  logic [LANES*NUM_SIZE-1:0] data_i,
  output logic signed [NUM_SIZE-1:0] max_c_o,
  output logic [LANE_W-1:0]          lane_c_o
`ifdef ARGMAX_TOP2_EN
  ,
  output logic signed [NUM_SIZE-1:0] max2_c_o,
  output logic [LANE_W-1:0]          lane2_c_o,
  output logic                       has2_c_o
`endif
);

  logic signed [NUM_SIZE-1:0] cur;

  // Scan lanes in ascending order; only a strictly greater score displaces,
  // so ties resolve to the lowest lane.
  always_comb begin
    max_c_o  = data_i[0 +: NUM_SIZE];
    lane_c_o = '0;
    cur      = '0;
`ifdef ARGMAX_TOP2_EN
    max2_c_o  = '0;
    lane2_c_o = '0;
    has2_c_o  = 1'b0;
`endif
    for (int unsigned k = 1; k < LANES; k++) begin
      cur = data_i[k*NUM_SIZE +: NUM_SIZE];
      if (cur > max_c_o) begin
`ifdef ARGMAX_TOP2_EN
        max2_c_o  = max_c_o;
        lane2_c_o = lane_c_o;
        has2_c_o  = 1'b1;
`endif
        max_c_o  = cur;
        lane_c_o = LANE_W'(k);
      end
`ifdef ARGMAX_TOP2_EN
      else if (!has2_c_o || (cur > max2_c_o)) begin
        max2_c_o  = cur;
        lane2_c_o = LANE_W'(k);
        has2_c_o  = 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/argmax_stream.sv
// argmax_stream: streaming argmax over frames of NUM_CLASSES signed scores,
// LANES scores per beat, BEATS = NUM_CLASSES/LANES beats per frame.
//   clk         - clock, rising edge
//   GlobalReset - synchronous active-high reset
//   bus         - argmax_stream_if.slave (beat input, result output)
// Optional macro ARGMAX_TOP2_EN adds the runner-up index output OutIndex2.
module argmax_stream import argmax_pkg::*; #(
  parameter int unsigned NUM_SIZE    = ARGMAX_NUM_SIZE,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned LANES       = 1
) (
  input logic           clk,
  input logic           GlobalReset,
  argmax_stream_if.slave bus
);

  localparam int unsigned IDX_W  = idx_width(NUM_CLASSES);
  localparam int unsigned BEATS  = NUM_CLASSES / LANES;
  localparam int unsigned CNT_W  = idx_width(BEATS);
  localparam int unsigned LANE_W = idx_width(LANES);

  argmax_state_e              state_q, state_d;
  logic [CNT_W-1:0]           beat_cnt_q, beat_cnt_d;
  logic signed [NUM_SIZE-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0]           run_idx_q, run_idx_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [NUM_SIZE-1:0] out_max_q, out_max_d;
  logic [IDX_W-1:0]           out_idx_q, out_idx_d;

  logic signed [NUM_SIZE-1:0] beat_max;
  logic [LANE_W-1:0]          beat_lane;
  logic [IDX_W-1:0]           beat_idx;
  logic signed [NUM_SIZE-1:0] mrg_max;
  logic [IDX_W-1:0]           mrg_idx;
  logic                       first_beat, last_beat, in_ready_c, accept;

`ifdef ARGMAX_TOP2_EN
  logic signed [NUM_SIZE-1:0] run2_max_q, run2_max_d;
  logic [IDX_W-1:0]           run2_idx_q, run2_idx_d;
  logic                       run2_has_q, run2_has_d;
  logic [IDX_W-1:0]           out_idx2_q, out_idx2_d;
  logic signed [NUM_SIZE-1:0] beat_max2;
  logic [LANE_W-1:0]          beat_lane2;
  logic                       beat_has2;
  logic [IDX_W-1:0]           beat_idx2;
  logic signed [NUM_SIZE-1:0] mrg2_max;
  logic [IDX_W-1:0]           mrg2_idx;
  logic                       mrg2_has;
`endif

  argmax_lane_reduce #(
    .NUM_SIZE (NUM_SIZE),
    .LANES    (LANES),
    .LANE_W   (LANE_W)
  ) u_reduce (
    .data_i   (bus.InData),
    .max_c_o  (beat_max),
    .lane_c_o (beat_lane)
`ifdef ARGMAX_TOP2_EN
    ,
    .max2_c_o  (beat_max2),
    .lane2_c_o (beat_lane2),
    .has2_c_o  (beat_has2)
`endif
  );

  assign first_beat = (state_q == ST_IDLE);
  assign last_beat  = (beat_cnt_q == CNT_W'(BEATS - 1));
  // Only the final beat needs a free result slot; earlier beats always go in.
  assign in_ready_c = !GlobalReset && !(last_beat && out_valid_q && !bus.OutReady);
  assign accept     = bus.InValid && in_ready_c;
  assign beat_idx   = IDX_W'(32'(beat_cnt_q) * LANES + 32'(beat_lane));
`ifdef ARGMAX_TOP2_EN
  assign beat_idx2  = IDX_W'(32'(beat_cnt_q) * LANES + 32'(beat_lane2));
`endif

  // Merge the beat into the running result. Running entries always carry
  // lower class indices, so the beat only wins on a strictly greater score.
  always_comb begin
    mrg_max = run_max_q;
    mrg_idx = run_idx_q;
`ifdef ARGMAX_TOP2_EN
    mrg2_max = run2_max_q;
    mrg2_idx = run2_idx_q;
    mrg2_has = run2_has_q;
`endif
    if (first_beat) begin
      mrg_max = beat_max;
      mrg_idx = beat_idx;
`ifdef ARGMAX_TOP2_EN
      mrg2_max = beat_max2;
      mrg2_idx = beat_idx2;
      mrg2_has = beat_has2;
`endif
    end else if (beat_max > run_max_q) begin
      mrg_max = beat_max;
      mrg_idx = beat_idx;
`ifdef ARGMAX_TOP2_EN
      mrg2_has = 1'b1;
      if (beat_has2 && (beat_max2 > run_max_q)) begin
        mrg2_max = beat_max2;
        mrg2_idx = beat_idx2;
      end else begin
        mrg2_max = run_max_q;
        mrg2_idx = run_idx_q;
      end
`endif
    end else begin
`ifdef ARGMAX_TOP2_EN
      mrg2_has = 1'b1;
      if (!run2_has_q || (beat_max > run2_max_q)) begin
        mrg2_max = beat_max;
        mrg2_idx = beat_idx;
      end
`endif
    end
  end

  // Next-state: beat counting, running result, result hand-off.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    out_valid_d = out_valid_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;
`ifdef ARGMAX_TOP2_EN
    run2_max_d = run2_max_q;
    run2_idx_d = run2_idx_q;
    run2_has_d = run2_has_q;
    out_idx2_d = out_idx2_q;
`endif
    if (out_valid_q && bus.OutReady) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      run_max_d = mrg_max;
      run_idx_d = mrg_idx;
`ifdef ARGMAX_TOP2_EN
      run2_max_d = mrg2_max;
      run2_idx_d = mrg2_idx;
      run2_has_d = mrg2_has;
`endif
      if (last_beat) begin
        state_d     = ST_IDLE;
        beat_cnt_d  = '0;
        out_valid_d = 1'b1;
        out_max_d   = mrg_max;
        out_idx_d   = mrg_idx;
`ifdef ARGMAX_TOP2_EN
        out_idx2_d = mrg2_idx;
`endif
      end else begin
        state_d    = ST_ACCUM;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '1;
`ifdef ARGMAX_TOP2_EN
      run2_max_q <= '0;
      run2_idx_q <= '0;
      run2_has_q <= 1'b0;
      out_idx2_q <= '1;
`endif
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
      out_idx_q   <= out_idx_d;
`ifdef ARGMAX_TOP2_EN
      run2_max_q <= run2_max_d;
      run2_idx_q <= run2_idx_d;
      run2_has_q <= run2_has_d;
      out_idx2_q <= out_idx2_d;
`endif
    end
  end

  assign bus.InReady  = in_ready_c;
  assign bus.OutValid = out_valid_q;
  assign bus.OutIndex = out_idx_q;
  assign bus.OutMax   = out_max_q;
`ifdef ARGMAX_TOP2_EN
  assign bus.OutIndex2 = out_idx2_q;
`endif

endmodule

// File: tb/tb_argmax_stream.sv
// tb_argmax_stream: directed checks of argmax_stream in the default 1-lane
// configuration and a 5-lane configuration; runner-up checks when
// ARGMAX_TOP2_EN is defined.
module tb_argmax_stream;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  argmax_stream_if #(.NUM_SIZE(26), .NUM_CLASSES(10), .LANES(1)) bus1 ();
  argmax_stream_if #(.NUM_SIZE(26), .NUM_CLASSES(10), .LANES(5)) bus5 ();

  argmax_stream #(.NUM_SIZE(26), .NUM_CLASSES(10), .LANES(1)) dut (
    .clk         (clk),
    .GlobalReset (rst),
    .bus         (bus1)
  );

  argmax_stream #(.NUM_SIZE(26), .NUM_CLASSES(10), .LANES(5)) dut5 (
    .clk         (clk),
    .GlobalReset (rst),
    .bus         (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 26-bit two's-complement encoding of a score, zero-extended for check_eq.
  function automatic logic [63:0] s26(input int v);
    logic [31:0] t;
    t = v;
    return {38'b0, t[25:0]};
  endfunction

  // Present one beat on bus1 and wait (bounded) until it is accepted.
  task automatic beat1(input int v);
    logic [31:0] t;
    bit ok;
    int n;
    t  = v;
    ok = 1'b0;
    n  = 0;
    bus1.InValid = 1'b1;
    bus1.InData  = t[25:0];
    while (!ok && n < 20) begin
      #1;
      ok = bus1.InReady;
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("beat1_accept", 64'(ok), 64'd1);
  endtask

  task automatic send1(input int fr[10], input int lo, input int hi);
    for (int i = lo; i < hi; i++) beat1(fr[i]);
    bus1.InValid = 1'b0;
  endtask

  task automatic beat5(input int a[5]);
    logic [31:0] t;
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    for (int k = 0; k < 5; k++) begin
      t = a[k];
      bus5.InData[k*26 +: 26] = t[25:0];
    end
    bus5.InValid = 1'b1;
    while (!ok && n < 20) begin
      #1;
      ok = bus5.InReady;
      @(posedge clk);
      #1;
      n++;
    end
    bus5.InValid = 1'b0;
    check_eq("beat5_accept", 64'(ok), 64'd1);
  endtask

  task automatic idle(input int n);
    bus1.InValid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect1(input string tag, input int idx, input int mx);
    check_eq({tag, "_valid"}, 64'(bus1.OutValid), 64'd1);
    check_eq({tag, "_index"}, 64'(bus1.OutIndex), 64'(idx));
    check_eq({tag, "_max"},   64'(bus1.OutMax),   s26(mx));
  endtask

  task automatic expect5(input string tag, input int idx, input int mx);
    check_eq({tag, "_valid"}, 64'(bus5.OutValid), 64'd1);
    check_eq({tag, "_index"}, 64'(bus5.OutIndex), 64'(idx));
    check_eq({tag, "_max"},   64'(bus5.OutMax),   s26(mx));
  endtask

  int fr[10];
  int b0[5];
  int b1[5];
  int c0;

  initial begin
    rst           = 1'b1;
    bus1.InValid  = 1'b0;
    bus1.InData   = '0;
    bus1.OutReady = 1'b1;
    bus5.InValid  = 1'b0;
    bus5.InData   = '0;
    bus5.OutReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    bus1.InValid = 1'b1;
    #1;
    check_eq("rst_in_ready",  64'(bus1.InReady),  64'd0);
    bus1.InValid = 1'b0;
    check_eq("rst_out_valid", 64'(bus1.OutValid), 64'd0);
    check_eq("rst_out_index", 64'(bus1.OutIndex), 64'hF);
    check_eq("rst_out_max",   64'(bus1.OutMax),   64'd0);
    check_eq("rst5_out_index", 64'(bus5.OutIndex), 64'hF);
`ifdef ARGMAX_TOP2_EN
    check_eq("rst_out_index2", 64'(bus1.OutIndex2), 64'hF);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reference frame: ties at 2,3,9 resolve to 2; one beat per cycle
    fr = '{5, -3, 9, 9, 0, 1, 2, -8, 4, 9};
    c0 = cyc;
    send1(fr, 0, 9);
    check_eq("a_no_early_valid", 64'(bus1.OutValid), 64'd0);
    send1(fr, 9, 10);
    check_eq("a_throughput", 64'(cyc - c0), 64'd10);
    expect1("a", 2, 9);
`ifdef ARGMAX_TOP2_EN
    check_eq("a_index2", 64'(bus1.OutIndex2), 64'd3);
`endif
    idle(1);
    check_eq("a_consumed", 64'(bus1.OutValid), 64'd0);

    // All scores at the most negative value
    fr = '{-33554432, -33554432, -33554432, -33554432, -33554432,
           -33554432, -33554432, -33554432, -33554432, -33554432};
    send1(fr, 0, 10);
    expect1("b", 0, -33554432);

    // Maximum in last position, then first position of a negative frame
    fr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    send1(fr, 0, 10);
    expect1("c", 9, 9);
    fr = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
    send1(fr, 0, 10);
    expect1("d", 0, -1);
    idle(1);

    // Back-pressure: result held, next frame streams up to its final beat
    bus1.OutReady = 1'b0;
    fr = '{0, 0, 0, 0, 7, 0, 0, 0, 0, 0};
    send1(fr, 0, 10);
    expect1("e1", 4, 7);
    fr = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 20};
    c0 = cyc;
    send1(fr, 0, 9);
    check_eq("e_pending_accept_cycles", 64'(cyc - c0), 64'd9);
    expect1("e1_held", 4, 7);
    bus1.InValid = 1'b1;
    bus1.InData  = 26'd20;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("e_final_blocked", 64'(bus1.InReady), 64'd0);
      @(posedge clk);
      #1;
      check_eq("e1_stable_index", 64'(bus1.OutIndex), 64'd4);
      check_eq("e1_stable_max",   64'(bus1.OutMax),   64'd7);
    end
    bus1.OutReady = 1'b1;
    #1;
    check_eq("e_final_ready", 64'(bus1.InReady), 64'd1);
    @(posedge clk);
    #1;
    bus1.InValid = 1'b0;
    expect1("e2", 9, 20);
    idle(1);
    check_eq("e2_consumed", 64'(bus1.OutValid), 64'd0);

    // Reset drops a pending result and a partial frame
    bus1.OutReady = 1'b0;
    fr = '{0, 0, 0, 5, 0, 0, 0, 0, 0, 0};
    send1(fr, 0, 10);
    expect1("f_pending", 3, 5);
    send1(fr, 0, 6);
    rst = 1'b1;
    #1;
    check_eq("f_rst_in_ready", 64'(bus1.InReady), 64'd0);
    @(posedge clk);
    #1;
    check_eq("f_rst_valid", 64'(bus1.OutValid), 64'd0);
    check_eq("f_rst_index", 64'(bus1.OutIndex), 64'hF);
    check_eq("f_rst_max",   64'(bus1.OutMax),   64'd0);
    rst = 1'b0;
    bus1.OutReady = 1'b1;
    fr = '{2, 2, 2, 2, 2, 2, 2, 2, 3, 2};
    send1(fr, 0, 4);
    check_eq("f_partial_discarded", 64'(bus1.OutValid), 64'd0);
    send1(fr, 4, 10);
    expect1("f_new", 8, 3);
    idle(1);

`ifdef ARGMAX_TOP2_EN
    // Runner-up with a tie for the maximum
    fr = '{3, 10, 7, 10, 0, 0, 0, 0, 0, 0};
    send1(fr, 0, 10);
    expect1("g", 1, 10);
    check_eq("g_index2", 64'(bus1.OutIndex2), 64'd3);
    idle(1);
`endif

    // Five lanes per beat
    b0 = '{1, 7, 3, 7, 0};
    b1 = '{6, 2, 8, 8, -1};
    beat5(b0);
    check_eq("h_no_early_valid", 64'(bus5.OutValid), 64'd0);
    beat5(b1);
    expect5("h", 7, 8);
`ifdef ARGMAX_TOP2_EN
    check_eq("h_index2", 64'(bus5.OutIndex2), 64'd8);
`endif
    b0 = '{9, 0, 0, 0, 9};
    b1 = '{9, 9, 9, 9, 9};
    beat5(b0);
    beat5(b1);
    expect5("i", 0, 9);
    b0 = '{-5, -4, -3, -2, -1};
    b1 = '{-9, -9, -9, -9, -1};
    beat5(b0);
    beat5(b1);
    expect5("j", 4, -1);
    idle(1);
    check_eq("j_consumed", 64'(bus5.OutValid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
